taus_arb: RTL and testbench

Shared-access controller for a three-component Tausworthe (taus88) uniform random generator. It contains the generator state and recurrence, and adds:

- a seed-load handshake with seed validation,
- a warm-up phase that discards early outputs,
- a round-robin arbiter that hands one 32-bit random word to one of NREQ requesters per cycle.

It sits between the seeding/config logic and the Box-Muller consumers that share one uniform source.

---
 rtl/taus_arb.sv | 97 +++++++++
 tb/tb_taus_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/taus_arb.sv
// taus_arb: taus88 uniform generator with seed handshake, warm-up discard and round-robin word arbitration
module taus_arb #(
  parameter int NREQ   = 4,
  parameter int WARMUP = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic [31:0]     seed_s0,
  input  logic [31:0]     seed_s1,
  input  logic [31:0]     seed_s2,
  output logic            seed_err,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd_data,
  output logic            rnd_valid,
  output logic            busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
  state_t          state_q;
  logic [31:0]     s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic [15:0]     cnt_q;
  logic [PW-1:0]   ptr_q, pick_d;
  logic [NREQ-1:0] gnt_q;
  logic [31:0]     rnd_data_q;
  logic            rnd_valid_q, seed_err_q, busy_q;
  logic            seed_acc, seed_ok;
  assign seed_ready = state_q != WARM;
  assign seed_acc   = seed_valid & seed_ready;
  assign seed_ok    = seed_s0 >= 32'd2 && seed_s1 >= 32'd8 && seed_s2 >= 32'd16;
  assign s0_d = ((s0_q & 32'hFFFFFFFE) << 12) ^ (((s0_q << 13) ^ s0_q) >> 19);
  assign s1_d = ((s1_q & 32'hFFFFFFF8) << 4) ^ (((s1_q << 2) ^ s1_q) >> 25);
  assign s2_d = ((s2_q & 32'hFFFFFFF0) << 17) ^ (((s2_q << 3) ^ s2_q) >> 11);
  assign gnt        = gnt_q;
  assign rnd_data   = rnd_data_q;
  assign rnd_valid  = rnd_valid_q;
  assign seed_err   = seed_err_q;
  assign busy       = busy_q;
  // Round-robin pick: scanning downward lets the closest request at/after the pointer win
  always_comb begin
    pick_d = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NREQ]) pick_d = PW'((int'(ptr_q) + k) % NREQ);
    end
  end
  // Controller: seed handling wins over grants; WARM discards words; RUN grants one word per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      seed_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      seed_err_q  <= 1'b0;
      if (seed_acc) begin
        if (!seed_ok) seed_err_q <= 1'b1;
        else begin
          s0_q    <= seed_s0;
          s1_q    <= seed_s1;
          s2_q    <= seed_s2;
          ptr_q   <= '0;
          cnt_q   <= 16'(WARMUP);
          state_q <= (WARMUP > 0) ? WARM : RUN;
          busy_q  <= WARMUP > 0;
        end
      end else if (state_q == WARM) begin
        s0_q  <= s0_d;
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        cnt_q <= cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      end else if (state_q == RUN && |req) begin
        gnt_q       <= NREQ'(1) << pick_d;
        rnd_data_q  <= s0_q ^ s1_q ^ s2_q;
        rnd_valid_q <= 1'b1;
        s0_q        <= s0_d;
        s1_q        <= s1_d;
        s2_q        <= s2_d;
        ptr_q       <= (int'(pick_d) == NREQ - 1) ? '0 : pick_d + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_taus_arb.sv
// tb_taus_arb: directed and random checks of two taus_arb instances (WARMUP=0 and WARMUP=16) against a behavioural model
module tb_taus_arb;
  logic        clk = 0, reset_n = 0, seed_valid = 0;
  logic [31:0] seed_s0 = 0, seed_s1 = 0, seed_s2 = 0;
  logic [3:0]  req = 0;
  logic        a_ready, a_err, a_valid, a_busy, b_ready, b_err, b_valid, b_busy;
  logic [3:0]  a_gnt, b_gnt;
  logic [31:0] a_data, b_data;
  int checks = 0, failures = 0;
  bit sel = 0;
  int mstate, mcnt, mptr, mwarm;
  logic [31:0] ms0, ms1, ms2;
  logic [3:0]  e_gnt;
  logic [31:0] e_data;
  logic        e_valid, e_err;

  taus_arb #(.NREQ(4), .WARMUP(0)) u_a (.clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed_ready(a_ready),
    .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2), .seed_err(a_err), .req(req), .gnt(a_gnt),
    .rnd_data(a_data), .rnd_valid(a_valid), .busy(a_busy));
  taus_arb #(.NREQ(4), .WARMUP(16)) u_b (.clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed_ready(b_ready),
    .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2), .seed_err(b_err), .req(req), .gnt(b_gnt),
    .rnd_data(b_data), .rnd_valid(b_valid), .busy(b_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0; mcnt = 0; mptr = 0; ms0 = 0; ms1 = 0; ms2 = 0;
    e_gnt = 0; e_data = 0; e_valid = 0; e_err = 0;
  endtask

  task automatic model_adv();
    ms0 = ((ms0 & 32'hFFFFFFFE) << 12) ^ (((ms0 << 13) ^ ms0) >> 19);
    ms1 = ((ms1 & 32'hFFFFFFF8) << 4) ^ (((ms1 << 2) ^ ms1) >> 25);
    ms2 = ((ms2 & 32'hFFFFFFF0) << 17) ^ (((ms2 << 3) ^ ms2) >> 11);
  endtask

  // mstate: 0 unseeded, 1 warming up, 2 running
  task automatic model_step(input logic sv, input logic [31:0] a, b, c, input logic [3:0] r);
    e_gnt = 0; e_valid = 0; e_err = 0;
    if (sv && mstate != 1) begin
      if (a >= 2 && b >= 8 && c >= 16) begin
        ms0 = a; ms1 = b; ms2 = c; mptr = 0;
        mcnt = mwarm; mstate = (mwarm > 0) ? 1 : 2;
      end else e_err = 1;
    end else if (mstate == 1) begin
      model_adv();
      mcnt--;
      if (mcnt == 0) mstate = 2;
    end else if (mstate == 2 && r != 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (mptr + k) % 4;
        if (r[i] && !e_valid) begin
          e_valid = 1; e_gnt = 4'(1 << i); e_data = ms0 ^ ms1 ^ ms2;
          mptr = (i + 1) % 4;
        end
      end
      model_adv();
    end
  endtask

  task automatic check_out(input string t);
    chk({t, ".gnt"},   sel ? b_gnt : a_gnt, e_gnt);
    chk({t, ".data"},  sel ? b_data : a_data, e_data);
    chk({t, ".valid"}, sel ? b_valid : a_valid, e_valid);
    chk({t, ".err"},   sel ? b_err : a_err, e_err);
    chk({t, ".busy"},  sel ? b_busy : a_busy, 32'(mstate == 1));
    chk({t, ".ready"}, sel ? b_ready : a_ready, 32'(mstate != 1));
  endtask

  task automatic tick(input string t, input logic sv, input logic [31:0] a, b, c, input logic [3:0] r);
    seed_valid = sv; seed_s0 = a; seed_s1 = b; seed_s2 = c; req = r;
    model_step(sv, a, b, c, r);
    @(posedge clk); #1;
    seed_valid = 0;
    check_out(t);
  endtask

  task automatic do_reset();
    reset_n = 0; seed_valid = 0; req = 0;
    #2;
    model_reset();
    check_out("reset");
    @(posedge clk); #1;
    reset_n = 1;
    check_out("reset_hold");
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic sv;
      logic [31:0] a, b, c;
      sv = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      c = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      tick("rand", sv, a, b, c, 4'($urandom));
    end
  endtask

  initial begin
    sel = 0; mwarm = 0;
    do_reset();
    tick("bad0", 1, 1, 8, 16, 0);
    tick("bad0_clr", 0, 0, 0, 0, 0);
    tick("bad1", 1, 2, 7, 16, 0);
    tick("bad1_clr", 0, 0, 0, 0, 0);
    tick("bad2", 1, 2, 8, 15, 0);
    tick("idle_req", 0, 0, 0, 0, 4'b0001);
    tick("seed", 1, 32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 0);
    tick("first", 0, 0, 0, 0, 4'b0001);
    chk("first_word", a_data, 32'h87654321);
    for (int i = 0; i < 8; i++) tick("stream", 0, 0, 0, 0, 4'b0001);
    tick("rr_seed", 1, 32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 0);
    for (int k = 0; k < 12; k++) begin
      tick("rr_all", 0, 0, 0, 0, 4'b1111);
      chk("rr_all_seq", a_gnt, 32'(1 << (k % 4)));
    end
    for (int k = 0; k < 4; k++) begin
      tick("rr_1010", 0, 0, 0, 0, 4'b1010);
      chk("rr_1010_seq", a_gnt, (k % 2 == 0) ? 32'b0010 : 32'b1000);
    end
    tick("collide", 1, 32'h11111111, 32'h22222222, 32'h44444444, 4'b0001);
    chk("collide_nognt", a_gnt, 0);
    tick("post_collide", 0, 0, 0, 0, 4'b1111);
    chk("collide_word", a_data, 32'h77777777);
    chk("collide_ptr", a_gnt, 32'b0001);
    random_run(200);
    sel = 1; mwarm = 16;
    do_reset();
    tick("w_seed", 1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h13579BDF, 4'b1111);
    for (int i = 0; i < 16; i++) begin
      tick("warm", 0, 0, 0, 0, 4'b1111);
      chk("warm_busy", b_busy, 32'(i < 15));
    end
    for (int i = 0; i < 8; i++) tick("w_stream", 0, 0, 0, 0, 4'b1111);
    random_run(200);
    tick("w_reseed", 1, 32'h00000100, 32'h00000200, 32'h00000300, 0);
    for (int i = 0; i < 5; i++) tick("w_mid", 0, 0, 0, 0, 4'b1111);
    reset_n = 0;
    #1;
    model_reset();
    check_out("async_rst");
    @(posedge clk); #1;
    reset_n = 1;
    tick("post_rst", 0, 0, 0, 0, 4'b1111);
    chk("post_rst_nognt", b_gnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
